// File: rtl/axi_apb_write_bridge.sv
// axi_apb_write_bridge
//   Takes one AXI write address and a fixed burst of BURST_LEN write-data
//   beats, issues one APB write per beat at consecutive addresses, and
//   returns a single write response covering the whole burst.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   awaddr/awvalid/awready   burst start address channel
//   wdata/wvalid/wready      write data beats (no WLAST; length is BURST_LEN)
//   bvalid/bready/bresp      burst response (2'b00 OKAY, 2'b10 SLVERR)
//   paddr/psel/penable/pwrite/pwdata/pready/pslverr   APB requester side
//
// state  | meaning
// IDLE   | waiting for AW, awready high
// WDATA  | waiting for the next W beat, wready high
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, held until pready
// RESP   | burst response presented until bready

module axi_apb_write_bridge #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ADDR_INC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int unsigned       CNT_W     = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] INC       = ADDR_W'(ADDR_INC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic               err_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (awvalid) begin
            addr_q     <= awaddr;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            state_q    <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (wvalid) begin
            paddr_q  <= addr_q;
            pwdata_q <= wdata;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            // A failing beat is remembered but the burst keeps going.
            err_q <= err_q | pslverr;
            if (beat_cnt_q == LAST_BEAT) begin
              state_q <= S_RESP;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
              addr_q     <= addr_q + INC;  // wraps modulo 2^ADDR_W
              state_q    <= S_WDATA;
            end
          end
        end
        S_RESP: begin
          if (bready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Handshakes decode the registered state; gating with rst drops an
  // in-flight APB transfer and any pending response during reset itself.
  assign awready = !rst && (state_q == S_IDLE);
  assign wready  = !rst && (state_q == S_WDATA);
  assign psel    = !rst && ((state_q == S_SETUP) || (state_q == S_ACCESS));
  assign penable = !rst && (state_q == S_ACCESS);
  assign pwrite  = psel;
  assign bvalid  = !rst && (state_q == S_RESP);
  assign bresp   = (bvalid && err_q) ? 2'b10 : 2'b00;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_axi_apb_write_bridge.sv
module tb_axi_apb_write_bridge;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;
  localparam int ADDR_INC  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;

  axi_apb_write_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .ADDR_INC(ADDR_INC)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observations gathered by run_burst, judged by the scenario tasks.
  logic [31:0] obs_addr [8];
  logic [31:0] obs_data [8];
  int          pen_cycles [8];
  int          n_xfer;
  int          bvalid_cyc;
  int          bvalid_cnt;
  logic [1:0]  bresp_first;
  bit          resp_stable;
  bit          aw_during_b;
  bit          awready_after;
  bit          wready_in_access;
  bit          addr_stable;
  bit          pwrite_ok;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one burst, reacting to the DUT handshakes, and records what the
  // APB and B channels did. Cycle 0 is the AW handshake cycle.
  task automatic run_burst(input logic [31:0] addr, input logic [31:0] dbase,
                           input int wait_beat, input int wait_n,
                           input int err_beat, input int bready_hold,
                           input int abort_at);
    int cyc = 0;
    int t0 = 0;
    int n_wsent = 0;
    int waits = 0;
    int b_cnt = 0;
    bit aw_done = 0;
    bit done = 0;
    logic [31:0] su_addr = '0;
    logic [31:0] su_data = '0;
    n_xfer = 0; bvalid_cyc = -1; bvalid_cnt = 0; bresp_first = 2'b00;
    resp_stable = 1; aw_during_b = 0; awready_after = 0;
    wready_in_access = 0; addr_stable = 1; pwrite_ok = 1;
    for (int i = 0; i < 8; i++) begin
      obs_addr[i] = '0; obs_data[i] = '0; pen_cycles[i] = 0;
    end
    while (!done && cyc < 200) begin
      if (psel && penable && n_xfer == abort_at) begin
        pready = 0; pslverr = 0; awvalid = 0; wvalid = 0; bready = 0;
        return;
      end
      awvalid = !aw_done;
      awaddr  = addr;
      wvalid  = aw_done && (n_wsent < BURST_LEN);
      wdata   = dbase + 32'(n_wsent);
      if (psel && penable) begin
        if (n_xfer == wait_beat && waits < wait_n) begin
          pready = 0;
          waits++;
        end else begin
          pready = 1;
        end
        pslverr = (n_xfer == err_beat);
      end else begin
        pready = 0;
        pslverr = 0;
      end
      if (bvalid) begin
        bready = (b_cnt >= bready_hold);
        b_cnt++;
      end else begin
        bready = 0;
      end

      if (!aw_done && awvalid && awready) begin
        aw_done = 1;
        t0 = cyc;
      end
      if (wvalid && wready) n_wsent++;
      if (psel && wready) wready_in_access = 1;
      if (psel && !pwrite) pwrite_ok = 0;
      if (psel && !penable) begin
        su_addr = paddr;
        su_data = pwdata;
      end
      if (psel && penable) begin
        if (paddr !== su_addr || pwdata !== su_data) addr_stable = 0;
        if (n_xfer < 8) pen_cycles[n_xfer]++;
        if (pready) begin
          if (n_xfer < 8) begin
            obs_addr[n_xfer] = paddr;
            obs_data[n_xfer] = pwdata;
          end
          n_xfer++;
        end
      end
      if (bvalid) begin
        if (bvalid_cnt == 0) begin
          bvalid_cyc  = cyc - t0;
          bresp_first = bresp;
        end else if (bresp !== bresp_first) begin
          resp_stable = 0;
        end
        bvalid_cnt++;
        if (awready) aw_during_b = 1;
      end

      if (bvalid && bready) begin
        step();
        awready_after = awready;
        done = 1;
      end else begin
        step();
        cyc++;
      end
    end
    awvalid = 0; wvalid = 0; bready = 0; pready = 0; pslverr = 0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL burst_timeout: no B handshake within 200 cycles (addr %h)", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    tests++;
    if ({awready, wready, psel, penable, pwrite, bvalid} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000000", {awready, wready, psel, penable, pwrite, bvalid});
    end
    rst = 0;
    #1;
    tests++;
    if (awready !== 1'b1) begin
      fails++;
      $display("FAIL reset_awready: got %b expected 1", awready);
    end
    tests++;
    if (paddr !== 32'h0 || pwdata !== 32'h0 || bresp !== 2'b00) begin
      fails++;
      $display("FAIL reset_regs: got paddr %h pwdata %h bresp %b expected 0 0 00", paddr, pwdata, bresp);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_a [4] = '{32'haabbccdd, 32'haabbcce1, 32'haabbcce5, 32'haabbcce9};
    logic [31:0] exp_d [4] = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003};
    run_burst(32'haabbccdd, 32'h10000000, -1, 0, -1, 0, -1);
    tests++;
    if (n_xfer !== 4) begin
      fails++;
      $display("FAIL zw_xfer_count: got %0d expected 4", n_xfer);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (obs_addr[i] !== exp_a[i] || obs_data[i] !== exp_d[i]) begin
        fails++;
        $display("FAIL zw_beat%0d: got %h/%h expected %h/%h", i, obs_addr[i], obs_data[i], exp_a[i], exp_d[i]);
      end
    end
    tests++;
    if (bvalid_cyc !== 13 || bresp_first !== 2'b00) begin
      fails++;
      $display("FAIL zw_bvalid: got cycle %0d bresp %b expected 13 00", bvalid_cyc, bresp_first);
    end
    tests++;
    if (awready_after !== 1'b1) begin
      fails++;
      $display("FAIL zw_awready_after: got %b expected 1", awready_after);
    end
    tests++;
    if (pwrite_ok !== 1'b1 || wready_in_access !== 1'b0) begin
      fails++;
      $display("FAIL zw_pwrite_wready: got pwrite_ok %b wready_in_apb %b expected 1 0", pwrite_ok, wready_in_access);
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] exp_a [4] = '{32'hfffffff8, 32'hfffffffc, 32'h00000000, 32'h00000004};
    run_burst(32'hfffffff8, 32'h20000000, -1, 0, -1, 0, -1);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (obs_addr[i] !== exp_a[i]) begin
        fails++;
        $display("FAIL wrap_beat%0d: got %h expected %h", i, obs_addr[i], exp_a[i]);
      end
    end
    tests++;
    if (bresp_first !== 2'b00) begin
      fails++;
      $display("FAIL wrap_bresp: got %b expected 00", bresp_first);
    end
  endtask

  task automatic test_wait_states();
    run_burst(32'h00001000, 32'h30000000, 1, 2, -1, 0, -1);
    tests++;
    if (pen_cycles[1] !== 3 || pen_cycles[0] !== 1 || pen_cycles[2] !== 1) begin
      fails++;
      $display("FAIL wait_penable: got %0d/%0d/%0d expected 1/3/1", pen_cycles[0], pen_cycles[1], pen_cycles[2]);
    end
    tests++;
    if (addr_stable !== 1'b1 || wready_in_access !== 1'b0) begin
      fails++;
      $display("FAIL wait_stable: got stable %b wready_in_apb %b expected 1 0", addr_stable, wready_in_access);
    end
    tests++;
    if (bvalid_cyc !== 15) begin
      fails++;
      $display("FAIL wait_bvalid_cycle: got %0d expected 15", bvalid_cyc);
    end
    tests++;
    if (obs_addr[1] !== 32'h00001004 || obs_data[1] !== 32'h30000001) begin
      fails++;
      $display("FAIL wait_beat1: got %h/%h expected 00001004/30000001", obs_addr[1], obs_data[1]);
    end
  endtask

  task automatic test_slave_error();
    run_burst(32'h00002000, 32'h40000000, -1, 0, 2, 0, -1);
    tests++;
    if (n_xfer !== 4 || obs_addr[3] !== 32'h0000200c) begin
      fails++;
      $display("FAIL err_all_beats: got %0d xfers last %h expected 4 0000200c", n_xfer, obs_addr[3]);
    end
    tests++;
    if (bresp_first !== 2'b10) begin
      fails++;
      $display("FAIL err_bresp: got %b expected 10", bresp_first);
    end
    run_burst(32'h00003000, 32'h50000000, -1, 0, -1, 0, -1);
    tests++;
    if (bresp_first !== 2'b00) begin
      fails++;
      $display("FAIL err_clean_after: got %b expected 00", bresp_first);
    end
  endtask

  task automatic test_resp_backpressure();
    run_burst(32'h00004000, 32'h60000000, -1, 0, 3, 5, -1);
    tests++;
    if (bvalid_cnt !== 6 || bvalid_cyc !== 13) begin
      fails++;
      $display("FAIL bp_bvalid_hold: got %0d cycles from %0d expected 6 from 13", bvalid_cnt, bvalid_cyc);
    end
    tests++;
    if (resp_stable !== 1'b1 || bresp_first !== 2'b10) begin
      fails++;
      $display("FAIL bp_bresp_stable: got stable %b bresp %b expected 1 10", resp_stable, bresp_first);
    end
    tests++;
    if (aw_during_b !== 1'b0 || awready_after !== 1'b1) begin
      fails++;
      $display("FAIL bp_awready: got during %b after %b expected 0 1", aw_during_b, awready_after);
    end
  endtask

  task automatic test_reset_mid_burst();
    run_burst(32'h00005000, 32'h70000000, -1, 0, 0, 0, 2);
    tests++;
    if (n_xfer !== 2 || !(psel && penable)) begin
      fails++;
      $display("FAIL rst_reach_beat2: got %0d xfers psel/penable %b%b expected 2 11", n_xfer, psel, penable);
    end
    rst = 1;
    #1;
    tests++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      fails++;
      $display("FAIL rst_apb_drop: got psel %b penable %b expected 0 0", psel, penable);
    end
    step();
    rst = 0;
    #1;
    tests++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      fails++;
      $display("FAIL rst_release: got awready %b bvalid %b expected 1 0", awready, bvalid);
    end
    run_burst(32'h00006000, 32'h80000000, -1, 0, -1, 0, -1);
    tests++;
    if (n_xfer !== 4 || obs_addr[0] !== 32'h00006000 || obs_data[0] !== 32'h80000000) begin
      fails++;
      $display("FAIL rst_next_burst: got %0d xfers first %h/%h expected 4 00006000/80000000", n_xfer, obs_addr[0], obs_data[0]);
    end
    tests++;
    if (bresp_first !== 2'b00 || bvalid_cyc !== 13) begin
      fails++;
      $display("FAIL rst_next_bresp: got %b at %0d expected 00 at 13", bresp_first, bvalid_cyc);
    end
  endtask

  initial begin
    rst = 1; awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0;
    bready = 0; pready = 0; pslverr = 0;
    test_reset();
    test_zero_wait();
    test_addr_wrap();
    test_wait_states();
    test_slave_error();
    test_resp_backpressure();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
